// File: rtl/keccak_sched_pkg.sv
// Shared definitions for the keccak scheduler, the keccak core and the CBD sampler.
// Holds the FSM states, tag widths, owner encodings and keccak mode codes.
package keccak_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_LOAD,
    ST_TAG,
    ST_RUN,
    ST_DRAIN
  } state_t;

  localparam int TAG_W_A = 16;
  localparam int TAG_W_B = 8;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  localparam logic [1:0] KMODE_SHA3_256 = 2'b00;
  localparam logic [1:0] KMODE_SHA3_512 = 2'b01;
  localparam logic [1:0] KMODE_SHAKE128 = 2'b10;
  localparam logic [1:0] KMODE_SHAKE256 = 2'b11;

  // Domain-separation word: client B only contributes its low TAG_W_B bits.
  function automatic logic [63:0] tag_word(input logic own, input logic [TAG_W_A-1:0] tag);
    if (own == OWNER_B)
      return {{(64 - TAG_W_B){1'b0}}, tag[TAG_W_B-1:0]};
    return {{(64 - TAG_W_A){1'b0}}, tag};
  endfunction

endpackage

// File: rtl/keccak_sched_if.sv
// Control/status bundle between the scheduler (master) and the keccak core (slave).
interface keccak_sched_if;
  logic [63:0] k_in;
  logic [1:0]  k_mode;
  logic        k_is_last;
  logic        k_in_valid;
  logic        k_start_calc;
  logic        k_ack;
  logic        k_out_buf_empty;

  modport master (
    output k_in, k_mode, k_is_last, k_in_valid, k_start_calc,
    input  k_ack, k_out_buf_empty
  );

  modport slave (
    input  k_in, k_mode, k_is_last, k_in_valid, k_start_calc,
    output k_ack, k_out_buf_empty
  );
endinterface

// File: rtl/keccak_sched_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to whoever was not served last.
module rr_arb2
  import keccak_sched_pkg::*;
(
  input  logic       req_a,
  input  logic       req_b,
  input  logic       last_owner,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    if (req_a && (!req_b || last_owner == OWNER_B))
      win = 2'b01;
    else if (req_b)
      win = 2'b10;
  end

endmodule

// File: rtl/keccak_sched.sv
// Shares one keccak core between the matrix parser (A) and the CBD noise generator (B):
// arbitrates, loads seed words plus a tag word, then holds ownership until done and drained.
module keccak_sched
  import keccak_sched_pkg::*;
#(
  parameter int SEED_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_a,
  input  logic [1:0]                    req_a_mode,
  input  logic [TAG_W_A-1:0]            req_a_tag,
  output logic                          gnt_a,
  input  logic                          done_a,
  input  logic                          req_b,
  input  logic [1:0]                    req_b_mode,
  input  logic [TAG_W_B-1:0]            req_b_tag,
  input  logic                          req_b_n,
  output logic                          gnt_b,
  input  logic                          done_b,
  output logic [$clog2(SEED_WORDS)-1:0] seed_addr,
  input  logic [63:0]                   seed_data,
  output logic                          cbd_n,
  output logic                          busy,
  output logic                          owner,
  keccak_sched_if.master                kif
);

  localparam int IDX_W = $clog2(SEED_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEED_WORDS - 1);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic               job_owner;
  logic               job_n;
  logic [1:0]         job_mode;
  logic [TAG_W_A-1:0] job_tag;
  logic               last_owner;
  logic               start_calc;
  logic               in_valid;
  logic               is_last;
  logic [1:0]         win;
  logic               owner_done;
  logic [63:0]        k_in;

  rr_arb2 u_arb (
    .req_a      (req_a),
    .req_b      (req_b),
    .last_owner (last_owner),
    .win        (win)
  );

  assign owner_done = (job_owner == OWNER_B) ? done_b : done_a;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      job_owner  <= OWNER_A;
      job_n      <= 1'b0;
      job_mode   <= '0;
      job_tag    <= '0;
      last_owner <= OWNER_B;
      gnt_a      <= 1'b0;
      gnt_b      <= 1'b0;
      start_calc <= 1'b0;
      in_valid   <= 1'b0;
      is_last    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      gnt_a      <= 1'b0;
      gnt_b      <= 1'b0;
      start_calc <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          // Requester inputs are only looked at here; the job registers carry the rest.
          if (win != 2'b00) begin
            state      <= ST_START;
            busy       <= 1'b1;
            start_calc <= 1'b1;
            gnt_a      <= win[0];
            gnt_b      <= win[1];
            job_owner  <= win[1] ? OWNER_B : OWNER_A;
            job_mode   <= win[1] ? req_b_mode : req_a_mode;
            job_tag    <= win[1] ? TAG_W_A'(req_b_tag) : req_a_tag;
            job_n      <= win[1] & req_b_n;
          end
        end
        ST_START: begin
          state    <= ST_LOAD;
          idx      <= '0;
          in_valid <= 1'b1;
        end
        ST_LOAD: begin
          if (kif.k_ack) begin
            if (idx == LAST_IDX) begin
              state   <= ST_TAG;
              is_last <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        ST_TAG: begin
          if (kif.k_ack) begin
            state    <= ST_RUN;
            in_valid <= 1'b0;
            is_last  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (owner_done)
            state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (kif.k_out_buf_empty) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            last_owner <= job_owner;
            job_owner  <= OWNER_A;
            job_n      <= 1'b0;
            job_mode   <= '0;
            job_tag    <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Seed data arrives combinationally from the regfile, so the word mux cannot be registered.
  always_comb begin
    k_in = '0;
    if (state == ST_LOAD)
      k_in = seed_data;
    else if (state == ST_TAG)
      k_in = tag_word(job_owner, job_tag);
  end

  assign seed_addr        = idx;
  assign cbd_n            = job_n;
  assign owner            = job_owner;
  assign kif.k_in         = k_in;
  assign kif.k_mode       = job_mode;
  assign kif.k_is_last    = is_last;
  assign kif.k_in_valid   = in_valid;
  assign kif.k_start_calc = start_calc;

endmodule

// File: tb/tb_keccak_sched.sv
// Randomized bench for keccak_sched against a transaction-level model that counts accepted
// words per job, plus directed scenarios with literal expectations.
module tb_keccak_sched;
  import keccak_sched_pkg::*;

  localparam int SW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, done_a, req_b, done_b, req_b_n;
  logic [1:0]  req_a_mode, req_b_mode;
  logic [15:0] req_a_tag;
  logic [7:0]  req_b_tag;
  logic        gnt_a, gnt_b, cbd_n, busy, owner;
  logic [1:0]  seed_addr;
  logic [63:0] seed_data;
  logic [63:0] seed_mem [SW];

  int n_vectors = 0;
  int n_checks = 0;
  int miscompares = 0;

  // Model: a job is a sequence of SW seed words plus one tag word, counted by m_acc.
  logic        m_valid = 1'b0;
  logic        m_busy, m_start, m_done, m_owner, m_last, m_n;
  int          m_acc;
  logic [1:0]  m_mode;
  logic [15:0] m_tag;

  always #5 clk = ~clk;

  assign seed_data = seed_mem[seed_addr];

  keccak_sched_if kif ();

  keccak_sched #(.SEED_WORDS(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_a      (req_a),
    .req_a_mode (req_a_mode),
    .req_a_tag  (req_a_tag),
    .gnt_a      (gnt_a),
    .done_a     (done_a),
    .req_b      (req_b),
    .req_b_mode (req_b_mode),
    .req_b_tag  (req_b_tag),
    .req_b_n    (req_b_n),
    .gnt_b      (gnt_b),
    .done_b     (done_b),
    .seed_addr  (seed_addr),
    .seed_data  (seed_data),
    .cbd_n      (cbd_n),
    .busy       (busy),
    .owner      (owner),
    .kif        (kif)
  );

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_word();
    if (m_acc < SW) return seed_mem[m_acc];
    if (m_owner) return {56'h0, m_tag[7:0]};
    return {48'h0, m_tag};
  endfunction

  task automatic check_output();
    logic exp_valid;
    if (!m_valid) return;
    exp_valid = m_busy && !m_start && (m_acc <= SW);
    cmp("busy", busy, m_busy);
    cmp("gnt_a", gnt_a, m_start && !m_owner);
    cmp("gnt_b", gnt_b, m_start && m_owner);
    cmp("start_calc", kif.k_start_calc, m_start);
    cmp("k_in_valid", kif.k_in_valid, exp_valid);
    cmp("k_is_last", kif.k_is_last, exp_valid && (m_acc == SW));
    if (exp_valid) begin
      cmp("k_in", kif.k_in, exp_word());
      if (m_acc < SW) cmp("seed_addr", seed_addr, m_acc[1:0]);
    end
    if (m_busy) begin
      cmp("k_mode", kif.k_mode, m_mode);
      cmp("owner", owner, m_owner);
      if (m_owner) cmp("cbd_n", cbd_n, m_n);
    end
  endtask

  task automatic model_update();
    if (!rst) begin
      m_valid = 1'b1;
      m_busy  = 1'b0;
      m_start = 1'b0;
      m_done  = 1'b0;
      m_acc   = 0;
      m_last  = 1'b1;
    end else if (!m_busy) begin
      if (req_a || req_b) begin
        m_owner = (req_a && (!req_b || m_last)) ? 1'b0 : 1'b1;
        m_busy  = 1'b1;
        m_start = 1'b1;
        m_done  = 1'b0;
        m_acc   = 0;
        m_mode  = m_owner ? req_b_mode : req_a_mode;
        m_tag   = m_owner ? {8'h00, req_b_tag} : req_a_tag;
        m_n     = req_b_n;
      end
    end else if (m_start) begin
      m_start = 1'b0;
    end else if (m_acc <= SW) begin
      if (kif.k_ack) m_acc++;
    end else if (!m_done) begin
      if (m_owner ? done_b : done_a) m_done = 1'b1;
    end else if (kif.k_out_buf_empty) begin
      m_busy = 1'b0;
      m_last = m_owner;
    end
  endtask

  // Inputs for the current cycle are set by the caller at the falling edge.
  task automatic apply_stimulus();
    check_output();
    model_update();
    n_vectors++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_to_idle();
    kif.k_ack = 1'b1;
    kif.k_out_buf_empty = 1'b1;
    done_a = 1'b1;
    done_b = 1'b1;
    for (int i = 0; i < 100 && m_busy; i++) apply_stimulus();
    done_a = 1'b0;
    done_b = 1'b0;
    if (m_busy) begin
      miscompares++;
      $display("[TB] FAIL run_to_idle: job still pending after 100 cycles");
    end
  endtask

  task automatic reseed();
    for (int i = 0; i < SW; i++) seed_mem[i] = {$urandom, $urandom};
  endtask

  initial begin
    logic [63:0] t1_words [5];
    t1_words = '{64'd1, 64'd2, 64'd3, 64'd4, 64'h0102};
    rst = 1'b0; req_a = 1'b0; req_b = 1'b0; done_a = 1'b0; done_b = 1'b0; req_b_n = 1'b0;
    req_a_mode = 2'b00; req_b_mode = 2'b00; req_a_tag = '0; req_b_tag = '0;
    kif.k_ack = 1'b0; kif.k_out_buf_empty = 1'b1;
    for (int i = 0; i < SW; i++) seed_mem[i] = 64'(i + 1);
    @(negedge clk);
    apply_stimulus();
    apply_stimulus();
    rst = 1'b1;
    cmp("reset_busy", busy, 0);
    cmp("reset_valid", kif.k_in_valid, 0);
    cmp("reset_start", kif.k_start_calc, 0);
    cmp("reset_gnt", {gnt_a, gnt_b}, 0);

    // A alone, zero-wait ack.
    $display("[TB] A alone, mode 01, tag 0102");
    req_a = 1'b1; req_a_mode = 2'b01; req_a_tag = 16'h0102; kif.k_ack = 1'b1;
    apply_stimulus();
    cmp("t1_gnt_a", gnt_a, 1);
    cmp("t1_start_calc", kif.k_start_calc, 1);
    req_a = 1'b0; req_a_tag = 16'hFFFF; req_a_mode = 2'b11;
    apply_stimulus();
    for (int i = 0; i < 5; i++) begin
      cmp("t1_k_in", kif.k_in, t1_words[i]);
      cmp("t1_is_last", kif.k_is_last, (i == 4) ? 64'd1 : 64'd0);
      cmp("t1_k_mode", kif.k_mode, 2'b01);
      apply_stimulus();
    end
    cmp("t1_run_valid", kif.k_in_valid, 0);
    done_a = 1'b1; apply_stimulus(); done_a = 1'b0; apply_stimulus();
    cmp("t1_idle_busy", busy, 0);

    // Tie after reset, foreign done ignored, slow drain, then B with ack stalls.
    $display("[TB] tie, drain and stall scenario");
    reseed();
    rst = 1'b0; apply_stimulus(); rst = 1'b1;
    req_a = 1'b1; req_a_mode = 2'b11; req_a_tag = 16'hBEEF;
    req_b = 1'b1; req_b_mode = 2'b10; req_b_tag = 8'hA5; req_b_n = 1'b1;
    apply_stimulus();
    cmp("t2_tie_gnt_a", gnt_a, 1);
    cmp("t2_tie_gnt_b", gnt_b, 0);
    req_a = 1'b0;
    repeat (6) apply_stimulus();
    done_b = 1'b1;
    repeat (3) apply_stimulus();
    cmp("t4_done_b_ignored", busy, 1);
    done_b = 1'b0; done_a = 1'b1; kif.k_out_buf_empty = 1'b0;
    apply_stimulus();
    done_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmp("t4_drain_busy", busy, 1);
      apply_stimulus();
    end
    kif.k_out_buf_empty = 1'b1;
    apply_stimulus();
    cmp("t4_drain_exit", busy, 0);
    req_a = 1'b1;
    apply_stimulus();
    cmp("t2_gnt_b", gnt_b, 1);
    cmp("t2_cbd_n", cbd_n, 1);
    cmp("t2_b_mode", kif.k_mode, 2'b10);
    req_b = 1'b0; req_b_n = 1'b0;
    apply_stimulus();
    apply_stimulus();
    apply_stimulus();
    kif.k_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) kif.k_ack = 1'b1;
      cmp("t3_stall_word", kif.k_in, seed_mem[2]);
      cmp("t3_stall_valid", kif.k_in_valid, 1);
      apply_stimulus();
    end
    cmp("t3_next_word", kif.k_in, seed_mem[3]);
    apply_stimulus();
    cmp("t2_b_tag", kif.k_in, 64'h00000000000000A5);
    apply_stimulus();
    done_b = 1'b1; apply_stimulus(); done_b = 1'b0; apply_stimulus();
    req_b = 1'b1;
    apply_stimulus();
    cmp("t2_next_tie_a", gnt_a, 1);
    req_a = 1'b0; req_b = 1'b0;
    run_to_idle();

    // Reset while loading seed word index 3, then a clean restart.
    $display("[TB] reset mid-load scenario");
    reseed();
    req_a = 1'b1; req_a_tag = 16'h1234; req_a_mode = 2'b01;
    apply_stimulus();
    req_a = 1'b0;
    repeat (4) apply_stimulus();
    cmp("t5_at_word3", seed_addr, 3);
    rst = 1'b0; apply_stimulus(); rst = 1'b1;
    cmp("t5_rst_busy", busy, 0);
    cmp("t5_rst_valid", kif.k_in_valid, 0);
    cmp("t5_rst_mode", kif.k_mode, 0);
    cmp("t5_rst_k_in", kif.k_in, 0);
    req_a = 1'b1; apply_stimulus(); req_a = 1'b0; apply_stimulus();
    cmp("t5_restart_addr", seed_addr, 0);
    cmp("t5_restart_word", kif.k_in, seed_mem[0]);
    run_to_idle();

    // Randomized traffic.
    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      if (!m_busy && $urandom_range(0, 3) == 0) reseed();
      rst        = ($urandom_range(0, 399) != 0);
      req_a      = ($urandom_range(0, 2) == 0);
      req_b      = ($urandom_range(0, 2) == 0);
      req_a_mode = 2'($urandom);
      req_b_mode = 2'($urandom);
      req_a_tag  = 16'($urandom);
      req_b_tag  = 8'($urandom);
      req_b_n    = 1'($urandom);
      done_a     = ($urandom_range(0, 3) == 0);
      done_b     = ($urandom_range(0, 3) == 0);
      kif.k_ack  = ($urandom_range(0, 3) != 0);
      kif.k_out_buf_empty = ($urandom_range(0, 2) != 0);
      apply_stimulus();
    end
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    run_to_idle();
    apply_stimulus();

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keccak_sched.md
# keccak_sched

Controller that shares the single keccak core (and its downstream CBD sampler) between two requesters: the matrix-expansion parser (client A) and the CBD noise generator (client B). It arbitrates round-robin, pulses `start_calc`, streams the 64-bit seed words plus one domain-separation tag word into the core under the `ack` handshake, and then holds ownership until the consuming client reports completion and the core's output FIFO has drained. It sits between the seed register file and the keccak/CBD datapath pair.

## Interface
- `SEED_WORDS`, default 4: 64-bit seed words per job (32-byte seed).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `req_a` in 1: client A job request, level; held until `gnt_a`.
- `req_a_mode` in 2: keccak mode for A.
- `req_a_tag` in 16: A tag (j‖i bytes).
- `gnt_a` out 1: one-cycle pulse when A's job starts.
- `done_a` in 1: A has consumed all samples it needs.
- `req_b`, `req_b_mode` (2), `req_b_tag` (8), `req_b_n` (1), `gnt_b`, `done_b`: same for client B; `req_b_n` selects eta=2 (0) / eta=3 (1).
- `seed_addr` out $clog2(SEED_WORDS): seed regfile read address; `seed_data` in 64: combinational read data, zero latency.
- `k_in` out 64, `k_mode` out 2, `k_is_last` out 1, `k_in_valid` out 1, `k_start_calc` out 1: keccak control.
- `k_ack` in 1, `k_out_buf_empty` in 1: keccak status.
- `cbd_n` out 1: eta select to CBD, held for the whole B job.
- `busy` out 1; `owner` out 1 (0 = A, 1 = B, valid while `busy`).

## Operation
- States: IDLE → START → LOAD → TAG → RUN → DRAIN → IDLE.
- IDLE: if any request is pending, arbitrate. Latch mode, tag, n and the winner into job registers. Requester inputs are ignored after latching.
- Arbitration: round-robin on a `last_owner` flag. If only one client requests, it wins. If both request, the client not served last wins. After reset `last_owner` = B, so A wins the first tie.
- START, 1 cycle: `k_start_calc`=1, `gnt_<owner>`=1, word index cleared.
- LOAD: `seed_addr`=index, `k_in`=`seed_data`, `k_in_valid`=1. On a cycle with `k_ack`=1 the index increments. The word after index SEED_WORDS-1 is accepted → TAG.
- TAG: `k_in`={48'b0, tag16} for A or {56'b0, tag8} for B; `k_in_valid`=1, `k_is_last`=1. On `k_ack` → RUN.
- RUN: wait for `done_<owner>`. Done from the non-owner is ignored.
- DRAIN: wait for `k_out_buf_empty`=1, then update `last_owner` and go to IDLE.
- `k_in`/`k_in_valid`/`k_is_last` stay stable until acked; `k_in_valid` never drops mid-word.
- `k_mode` and `cbd_n` are driven from the job registers from START through DRAIN.
- `req_x` deasserting mid-job does not abort; the job runs to completion.

## Timing
- Reset values: all outputs 0; `state`=IDLE; `last_owner`=B.
- Reset mid-job: the next edge forces IDLE and all outputs to 0. The keccak core shares `rst` and clears too.
- Request sampled in IDLE at cycle 0 → START at cycle 1 (`gnt`, `start_calc`) → first `k_in_valid` at cycle 2.
- Zero-wait `k_ack` gives SEED_WORDS+1 consecutive valid cycles (cycles 2..SEED_WORDS+2).
- `done_x` and `k_out_buf_empty` asserted together in RUN: go to DRAIN, leave DRAIN on the next cycle (each state takes at least 1 cycle).
- Back-to-back jobs: at least 1 IDLE cycle between DRAIN exit and the next START.
- `busy` = (state != IDLE), registered.

## Structure
- Shared package holds: the state enum, TAG_W_A=16, TAG_W_B=8, owner encodings, and the keccak mode constants (shared with keccak and CBD).
- Sub-module `rr_arb2`: 2-way round-robin arbiter. Inputs: two requests and `last_owner`. Output: winner one-hot. Purely combinational.
- Everything else lives in `keccak_sched`: FSM, word counter, job registers.

## Test plan
- A alone, mode=2'b01, tag=16'h0102, seed words 1..4, `k_ack` tied 1 → `gnt_a` at cycle 1; `k_in` = 1,2,3,4,16'h0102 on cycles 2–6; `k_is_last` only on cycle 6.
- A and B request in the same cycle after reset → A granted; after A's `done_a`, B granted with `cbd_n`=`req_b_n`; the next tie goes to A.
- `k_ack` low for 3 cycles on word 2 → `k_in`=word2 and `k_in_valid`=1 held stable for 4 cycles; no word skipped or duplicated.
- `done_b` asserted while A owns → ignored; A leaves RUN only on `done_a`. `k_out_buf_empty`=0 for 5 cycles after `done_a` → stays in DRAIN 5 cycles.
- `rst`=0 during LOAD word 3 → next cycle all outputs 0 and `busy`=0; a new A request restarts from word 0.
- `req_a` dropped after `gnt_a` → job completes with the latched tag and mode.
